ram_sp_clr: RTL and testbench

Parametrised single-port synchronous RAM: the successor to the team's fixed 8x4 RAM. It generalises data and address width, adds a selectable read-during-write mode and an optional output register, and registers reads with a `rd_valid` strobe. A built-in clear sequencer zeroes every location after reset or on request. It sits wherever the design needs small scratch storage behind a simple `wr`/`rd`/`add` port.

---
 rtl/ram_pkg.sv | 12 +
 rtl/ram_clr_ctrl.sv | 60 ++++++
 rtl/ram_sp_clr.sv | 98 +++++++++
 tb/tb_ram_sp_clr.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and constants for the clearable single-port RAM
package ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

endpackage

// File: rtl/ram_clr_ctrl.sv
// rtl/ram_clr_ctrl.sv - clear sequencer: sweeps every address once, writing zero
module ram_clr_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The terminal test stops the sweep at the last word, so ptr never wraps.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        if (ptr_q == LAST_ADDR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = ptr_q;

endmodule

// File: rtl/ram_sp_clr.sv
// rtl/ram_sp_clr.sv - parametrised single-port RAM with registered reads,
// selectable read-during-write mode and a built-in clear sequencer
module ram_sp_clr
  import ram_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 3,
  parameter int RD_MODE = 0,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] add,
  input  logic              clr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_en, rd_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, rd_word;
  logic [DATA_W-1:0] rd1_q;
  logic              vld1_q;

  ram_clr_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_clr_ctrl (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  assign wr_en     = wr & ~busy;
  assign rd_en     = rd & ~busy;
  assign mem_we    = clr_we | wr_en;
  assign mem_addr  = clr_we ? clr_addr : add;
  assign mem_wdata = clr_we ? '0 : data_in;

  // Write-first mode forwards the incoming word instead of the stored one.
  assign rd_word = (RD_MODE == WR_FIRST && wr_en) ? data_in : mem_q[add];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_q  <= '0;
      vld1_q <= 1'b0;
    end else begin
      vld1_q <= rd_en;
      if (rd_en) begin
        rd1_q <= rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] rd2_q;
      logic              vld2_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd2_q  <= '0;
          vld2_q <= 1'b0;
        end else begin
          vld2_q <= vld1_q;
          if (vld1_q) begin
            rd2_q <= rd1_q;
          end
        end
      end

      assign data_out = rd2_q;
      assign rd_valid = vld2_q;
    end else begin : g_no_out_reg
      assign data_out = rd1_q;
      assign rd_valid = vld1_q;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sp_clr.sv
// tb/tb_ram_sp_clr.sv - self-checking bench driving two RAM configurations
// in lockstep against a per-instance behavioural model
module tb_ram_sp_clr;

  logic       clk = 1'b0;
  logic       rst, wr, rd, clr;
  logic [3:0] add;
  logic [7:0] din;

  logic [3:0] dout0;
  logic       vld0, busy0;
  logic [7:0] dout1;
  logic       vld1, busy1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  ram_sp_clr #(
    .DATA_W(4), .ADDR_W(3), .RD_MODE(0), .OUT_REG(0)
  ) dut0 (
    .clk(clk), .rst(rst), .data_in(din[3:0]), .wr(wr), .rd(rd),
    .add(add[2:0]), .clr(clr), .data_out(dout0), .rd_valid(vld0), .busy(busy0)
  );

  ram_sp_clr #(
    .DATA_W(8), .ADDR_W(4), .RD_MODE(1), .OUT_REG(1)
  ) dut1 (
    .clk(clk), .rst(rst), .data_in(din), .wr(wr), .rd(rd),
    .add(add), .clr(clr), .data_out(dout1), .rd_valid(vld1), .busy(busy1)
  );

  typedef struct {
    int         due;
    logic [7:0] val;
  } rd_t;

  int         dep  [2] = '{8, 16};
  int         lat  [2] = '{1, 2};
  int         mode [2] = '{0, 1};
  logic [7:0] mask [2] = '{8'h0F, 8'hFF};

  logic [7:0] mem_m [2][16];
  int         cnt   [2];
  logic [7:0] exp_d [2];
  logic       exp_v [2];
  rd_t        pq0[$];
  rd_t        pq1[$];

  task automatic push_rd(input int d, input rd_t r);
    if (d == 0) pq0.push_back(r);
    else        pq1.push_back(r);
  endtask

  task automatic model_edge();
    cyc++;
    for (int d = 0; d < 2; d++) begin
      int         a;
      logic [7:0] dd;
      rd_t        r;
      a  = int'(add) % dep[d];
      dd = din & mask[d];
      if (rst) begin
        cnt[d]   = dep[d];
        exp_d[d] = 8'h00;
        for (int i = 0; i < 16; i++) mem_m[d][i] = 8'h00;
        if (d == 0) pq0.delete();
        else        pq1.delete();
      end else if (cnt[d] > 0) begin
        cnt[d]--;
      end else begin
        if (rd) begin
          r.due = cyc + lat[d] - 1;
          r.val = (mode[d] == 1 && wr) ? dd : mem_m[d][a];
          push_rd(d, r);
        end
        if (wr) mem_m[d][a] = dd;
        if (clr) begin
          cnt[d] = dep[d];
          for (int i = 0; i < 16; i++) mem_m[d][i] = 8'h00;
        end
      end
      exp_v[d] = 1'b0;
      if (d == 0 && pq0.size() > 0 && pq0[0].due == cyc) begin
        r = pq0.pop_front();
        exp_v[d] = 1'b1;
        exp_d[d] = r.val;
      end
      if (d == 1 && pq1.size() > 0 && pq1[0].due == cyc) begin
        r = pq1.pop_front();
        exp_v[d] = 1'b1;
        exp_d[d] = r.val;
      end
    end
  endtask

  task automatic check_outputs();
    tests += 6;
    assert (busy0 === (cnt[0] > 0))
      else begin fails++; $error("FAIL busy0 cyc=%0d got=%b exp=%b", cyc, busy0, cnt[0] > 0); end
    assert (vld0 === exp_v[0])
      else begin fails++; $error("FAIL rd_valid0 cyc=%0d got=%b exp=%b", cyc, vld0, exp_v[0]); end
    assert (dout0 === exp_d[0][3:0])
      else begin fails++; $error("FAIL data_out0 cyc=%0d got=%h exp=%h", cyc, dout0, exp_d[0][3:0]); end
    assert (busy1 === (cnt[1] > 0))
      else begin fails++; $error("FAIL busy1 cyc=%0d got=%b exp=%b", cyc, busy1, cnt[1] > 0); end
    assert (vld1 === exp_v[1])
      else begin fails++; $error("FAIL rd_valid1 cyc=%0d got=%b exp=%b", cyc, vld1, exp_v[1]); end
    assert (dout1 === exp_d[1])
      else begin fails++; $error("FAIL data_out1 cyc=%0d got=%h exp=%h", cyc, dout1, exp_d[1]); end
  endtask

  task automatic step(input logic r, input logic w, input logic rdi,
                      input logic [3:0] a, input logic [7:0] d, input logic c);
    rst = r; wr = w; rd = rdi; add = a; din = d; clr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; add = '0; din = '0; clr = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    idle(17);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 4'(i), 8'h00, 1'b0);
    idle(2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 4'(i), 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'(i), 8'h00, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 4'd5, 8'h0A, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'd5, 8'h06, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd5, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd15, 8'h5A, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd15, 8'h00, 1'b0);
    idle(3);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 4'(i), 8'hFF, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 1'b0, 4'd2, 8'h33, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd2, 8'h00, 1'b1);
    idle(15);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 4'(i), 8'h00, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 4'd5, 8'h0C, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd5, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'd5, 8'h00, 1'b0);
    idle(18);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)), ($urandom_range(0, 59) == 0));
    end
    idle(20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
